// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared channel count and channel index type for the round-robin mux
package rr_mux_pkg;
  localparam int N_CH = 4;
  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: combinational rotating-priority 4-way arbiter, search starts at ptr
import rr_mux_pkg::*;
module rr_arbiter_4 (
  input  logic [N_CH-1:0] req,
  input  ch_idx_t         ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt,
  output ch_idx_t         idx
);
  logic    found;
  ch_idx_t c;
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    c     = ptr;
    for (int k = 0; k < N_CH; k++) begin
      c = ptr + ch_idx_t'(k);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    gnt = (found && en) ? (N_CH'(1) << idx) : '0;
  end
endmodule

// File: rtl/rr_mux_4_1_buf.sv
// rr_mux_4_1_buf: round-robin 4:1 selector with single-entry registered output
// out_src port and register exist only when RR_MUX_SRC_ID_EN is defined.
import rr_mux_pkg::*;
module rr_mux_4_1_buf #(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_valid,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic [N_CH-1:0] in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready
`ifdef RR_MUX_SRC_ID_EN
  , output ch_idx_t       out_src
`endif
);
  ch_idx_t        ptr_q, ptr_d, g;
  logic           full_q, full_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   d [N_CH];
  logic [N_CH-1:0] gnt;
  logic           can_load, xfer;
  assign d        = '{d0, d1, d2, d3};
  assign can_load = !full_q | out_ready;
  // Gating with rst keeps any transfer out of the reset cycle.
  rr_arbiter_4 u_arb (
    .req (in_valid),
    .ptr (ptr_q),
    .en  (can_load & !rst),
    .gnt (gnt),
    .idx (g)
  );
  assign in_ready  = gnt;
  assign xfer      = |gnt;
  assign out_valid = full_q;
  assign out_data  = data_q;
  always_comb begin
    ptr_d  = xfer ? g + 2'd1 : ptr_q;
    data_d = xfer ? d[g] : data_q;
    full_d = xfer ? 1'b1 : (out_ready ? 1'b0 : full_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end
`ifdef RR_MUX_SRC_ID_EN
  ch_idx_t src_q;
  assign out_src = src_q;
  always_ff @(posedge clk) begin
    if (rst) src_q <= '0;
    else if (xfer) src_q <= g;
  end
`endif
endmodule
